// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder, one full-adder cell and a carry flip-flop
//   in_clk, in_rst (sync, active-high), in_start, in_a, in_b, in_carry -> inputs
//   out_busy (ADD), out_ready (DONE pulse), out_sum, out_carry -> outputs
//   `define SERIAL_ADDER_OVERFLOW_EN adds out_overflow (signed overflow, held with out_sum)
module serial_adder #(
    parameter int BITS = 16
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_start,
    input  logic [BITS-1:0] in_a,
    input  logic [BITS-1:0] in_b,
    input  logic            in_carry,
    output logic            out_busy,
    output logic            out_ready,
    output logic [BITS-1:0] out_sum,
    output logic            out_carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic            out_overflow
`endif
);
    localparam int CW = $clog2(BITS);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state, nxt;
    logic [BITS-1:0] sa, sb, ss;
    logic [CW-1:0] cnt;
    logic c, s, co, last;
    always_comb begin
        s    = sa[0] ^ sb[0] ^ c;
        co   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        last = cnt == CW'(BITS - 1);
        nxt  = state == IDLE ? (in_start ? ADD : IDLE) :
               state == ADD  ? (last ? DONE : ADD) : IDLE;
    end
    assign out_busy  = state == ADD;
    assign out_ready = state == DONE;
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            ss        <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            out_overflow <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == IDLE && in_start) begin
                sa  <= in_a;
                sb  <= in_b;
                c   <= in_carry;
                cnt <= '0;
                ss  <= '0;
            end else if (state == ADD) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                ss  <= {s, ss[BITS-1:1]};
                c   <= co;
                cnt <= cnt + 1'b1;
                if (last) begin
                    out_sum   <= {s, ss[BITS-1:1]};
                    out_carry <= co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    // c here is the carry into the MSB, co the carry out of it
                    out_overflow <= c ^ co;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;
    localparam int BITS = 16;
    logic clk = 1'b0;
    logic rst, start, cin;
    logic [BITS-1:0] a, b;
    logic busy, ready, cout;
    logic [BITS-1:0] sum;
    logic ovf;
    int vectors = 0;
    int miscompares = 0;
    logic [BITS-1:0] last_sum;
    logic last_carry;

    always #5 clk = ~clk;

    serial_adder #(.BITS(BITS)) dut (
        .in_clk(clk),
        .in_rst(rst),
        .in_start(start),
        .in_a(a),
        .in_b(b),
        .in_carry(cin),
        .out_busy(busy),
        .out_ready(ready),
        .out_sum(sum),
        .out_carry(cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .out_overflow(ovf)
`endif
    );
`ifndef SERIAL_ADDER_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    function automatic logic [BITS:0] model(input logic [BITS-1:0] x, input logic [BITS-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{BITS{1'b0}}, ci};
    endfunction

    function automatic logic model_ovf(input logic [BITS-1:0] x, input logic [BITS-1:0] y, input logic ci);
        logic [BITS:0] r;
        r = model(x, y, ci);
        return (x[BITS-1] == y[BITS-1]) && (r[BITS-1] != x[BITS-1]);
    endfunction

    // Issues one request from IDLE and observes BITS+4 cycles; positions are counted
    // in sampling negedges after the start drive.
    task automatic run_add(input logic [BITS-1:0] x, input logic [BITS-1:0] y, input logic ci,
                           output logic [BITS-1:0] rs, output logic rc, output logic ro,
                           output int ready_at, output int ready_cnt, output int busy_cnt,
                           output logic [BITS-1:0] mid_sum);
        ready_at = -1; ready_cnt = 0; busy_cnt = 0; rs = 'x; rc = 1'bx; ro = 1'bx; mid_sum = 'x;
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = ci;
        for (int i = 1; i <= BITS + 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                a = $urandom; b = $urandom; cin = $urandom;
            end
            if (i == BITS) mid_sum = sum;
            if (busy) busy_cnt++;
            if (ready) begin
                ready_cnt++;
                if (ready_at < 0) begin
                    ready_at = i; rs = sum; rc = cout; ro = ovf;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({busy, ready, cout, sum} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: busy=%b ready=%b carry=%b sum=%h, required all 0", i, busy, ready, cout, sum);
            end
        end
        last_sum = '0; last_carry = 1'b0;
    endtask

    task automatic test_basic();
        logic [BITS-1:0] rs, ms; logic rc, ro; int at, rn, bn;
        run_add(16'd234, 16'd123, 1'b0, rs, rc, ro, at, rn, bn, ms);
        vectors++;
        if (bn !== BITS) begin miscompares++; $display("FAIL basic_busy: %0d cycles, required %0d", bn, BITS); end
        vectors++;
        if (at !== BITS + 1 || rn !== 1) begin miscompares++; $display("FAIL basic_latency: ready at %0d (%0d pulses), required at %0d (1 pulse)", at, rn, BITS + 1); end
        vectors++;
        if (rs !== 16'd357 || rc !== 1'b0) begin miscompares++; $display("FAIL basic_sum: %0d/%b, required 357/0", rs, rc); end
        vectors++;
        if (ms !== last_sum) begin miscompares++; $display("FAIL basic_hold: %h during ADD, required %h", ms, last_sum); end
        last_sum = 16'd357; last_carry = 1'b0;
    endtask

    task automatic test_wrap();
        logic [BITS-1:0] rs, ms; logic rc, ro; int at, rn, bn;
        run_add(16'hFFFF, 16'h0001, 1'b0, rs, rc, ro, at, rn, bn, ms);
        vectors++;
        if (rs !== 16'h0000 || rc !== 1'b1) begin miscompares++; $display("FAIL wrap_sum: %h/%b, required 0000/1", rs, rc); end
        run_add(16'h0000, 16'h0000, 1'b1, rs, rc, ro, at, rn, bn, ms);
        vectors++;
        if (rs !== 16'h0001 || rc !== 1'b0) begin miscompares++; $display("FAIL cin_only: %h/%b, required 0001/0", rs, rc); end
        vectors++;
        if (ms !== 16'h0000) begin miscompares++; $display("FAIL wrap_hold: %h during ADD, required 0000", ms); end
        last_sum = 16'h0001; last_carry = 1'b0;
    endtask

    task automatic test_ignore_start();
        int rn = 0, bn = 0; logic [BITS-1:0] rs = 'x;
        @(negedge clk);
        start = 1'b1; a = 16'd234; b = 16'd123; cin = 1'b0;
        for (int i = 1; i <= BITS + 8; i++) begin
            @(negedge clk);
            start = (i >= 3 && i <= 8);
            a = 16'd5; b = 16'd5; cin = $urandom;
            if (busy) bn++;
            if (ready) begin rn++; rs = sum; end
        end
        start = 1'b0;
        vectors++;
        if (rn !== 1 || rs !== 16'd357) begin miscompares++; $display("FAIL ignore_start: %0d pulses sum %0d, required 1 pulse sum 357", rn, rs); end
        vectors++;
        if (bn !== BITS) begin miscompares++; $display("FAIL ignore_busy: %0d busy cycles, required %0d", bn, BITS); end
        last_sum = 16'd357; last_carry = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [BITS-1:0] rs, ms; logic rc, ro; int at, rn, bn;
        int late = 0;
        @(negedge clk);
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, ready, cout, sum, ovf} !== '0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b ready=%b carry=%b sum=%h ovf=%b, required all 0", busy, ready, cout, sum, ovf);
        end
        for (int i = 0; i < BITS + 4; i++) begin
            @(negedge clk);
            if (ready || busy) late++;
        end
        vectors++;
        if (late !== 0) begin miscompares++; $display("FAIL abort_quiet: %0d busy/ready cycles, required 0", late); end
        run_add(16'd1000, 16'd24, 1'b0, rs, rc, ro, at, rn, bn, ms);
        vectors++;
        if (rs !== 16'd1024 || rc !== 1'b0 || at !== BITS + 1) begin miscompares++; $display("FAIL after_abort: %0d/%b at %0d, required 1024/0 at %0d", rs, rc, at, BITS + 1); end
        last_sum = 16'd1024; last_carry = 1'b0;
    endtask

    task automatic test_random();
        logic [BITS-1:0] x, y, rs, ms; logic ci, rc, ro; logic [BITS:0] e; int at, rn, bn;
        for (int n = 0; n < 24; n++) begin
            x = $urandom; y = $urandom; ci = $urandom;
            if (n == 0) begin x = '1; y = '1; ci = 1'b1; end
            e = model(x, y, ci);
            run_add(x, y, ci, rs, rc, ro, at, rn, bn, ms);
            vectors++;
            if (rs !== e[BITS-1:0] || rc !== e[BITS] || at !== BITS + 1 || rn !== 1) begin
                miscompares++;
                $display("FAIL random %h+%h+%b: %h/%b at %0d x%0d, required %h/%b at %0d x1", x, y, ci, rs, rc, at, rn, e[BITS-1:0], e[BITS], BITS + 1);
            end
            vectors++;
            if (ms !== last_sum) begin miscompares++; $display("FAIL random_hold: %h during ADD, required %h", ms, last_sum); end
`ifdef SERIAL_ADDER_OVERFLOW_EN
            vectors++;
            if (ro !== model_ovf(x, y, ci)) begin miscompares++; $display("FAIL random_ovf %h+%h+%b: %b, required %b", x, y, ci, ro, model_ovf(x, y, ci)); end
`endif
            last_sum = e[BITS-1:0]; last_carry = e[BITS];
        end
    endtask

    task automatic test_back_to_back();
        int pos[$];
        logic [BITS-1:0] got[$];
        logic [BITS:0] e;
        logic [BITS-1:0] x, y;
        x = $urandom; y = $urandom;
        e = model(x, y, 1'b0);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = 1'b0;
        for (int i = 1; i <= 3 * (BITS + 2) + 1; i++) begin
            @(negedge clk);
            if (ready) begin pos.push_back(i); got.push_back(sum); end
        end
        start = 1'b0;
        vectors++;
        if (pos.size() != 3) begin
            miscompares++; $display("FAIL b2b_count: %0d pulses, required 3", pos.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (pos[k] != BITS + 1 + k * (BITS + 2) || got[k] !== e[BITS-1:0]) begin
                    miscompares++;
                    $display("FAIL b2b_%0d: at %0d sum %h, required at %0d sum %h", k, pos[k], got[k], BITS + 1 + k * (BITS + 2), e[BITS-1:0]);
                end
            end
        end
        repeat (BITS + 4) @(negedge clk);
        vectors++;
        if (busy || ready) begin miscompares++; $display("FAIL b2b_drain: busy=%b ready=%b, required 0/0", busy, ready); end
        last_sum = e[BITS-1:0]; last_carry = e[BITS];
    endtask

`ifdef SERIAL_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [BITS-1:0] rs, ms; logic rc, ro; int at, rn, bn;
        run_add(16'h7FFF, 16'h0001, 1'b0, rs, rc, ro, at, rn, bn, ms);
        vectors++;
        if (rs !== 16'h8000 || ro !== 1'b1 || rc !== 1'b0) begin miscompares++; $display("FAIL ovf_pos: %h ovf=%b c=%b, required 8000 ovf=1 c=0", rs, ro, rc); end
        run_add(16'hFFFF, 16'h0001, 1'b0, rs, rc, ro, at, rn, bn, ms);
        vectors++;
        if (rs !== 16'h0000 || ro !== 1'b0 || rc !== 1'b1) begin miscompares++; $display("FAIL ovf_wrap: %h ovf=%b c=%b, required 0000 ovf=0 c=1", rs, ro, rc); end
        last_sum = 16'h0000; last_carry = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_back_to_back();
`ifdef SERIAL_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-cycle two's-complement adder. It is the additive counterpart to the combinational ripple-borrow subtractor in the arithmetics library.
- Processes one bit per clock using a single full-adder cell and a carry flip-flop. This trades latency for area.
- Serves as a shared add unit in sequential datapaths: accumulators and multi-cycle multipliers/dividers.

Parameters:
- BITS, 16, operand and result width in bits (>= 2).

Ports:
- in_clk  in  1  system clock, all state updates on rising edge
- in_rst  in  1  synchronous reset, active-high
- in_start  in  1  request: latch operands and begin addition; honoured only in IDLE
- in_a  in  BITS  first operand, sampled on the accepted start edge
- in_b  in  BITS  second operand, sampled on the accepted start edge
- in_carry  in  1  carry-in, sampled on the accepted start edge
- out_busy  out  1  high while an addition is in progress (state ADD)
- out_ready  out  1  one-cycle pulse: result valid (state DONE)
- out_sum  out  BITS  result a + b + carry-in mod 2^BITS; held until the next result
- out_carry  out  1  carry-out of the MSB; held with out_sum

Behaviour:
- Clock and reset: one clock, in_clk. Reset in_rst is synchronous and active-high.
- Reset values: state IDLE, out_busy 0, out_ready 0, out_sum 0, out_carry 0. Internal operand shift registers, carry flip-flop and bit counter are all 0.
- Reset mid-operation: aborts the addition. The next cycle is IDLE with all outputs at reset values. No out_ready pulse is produced for the aborted request.
- FSM states: IDLE, ADD, DONE.
- IDLE -> ADD: on an edge with in_start=1.
  - Latches in_a and in_b into shift registers sa and sb.
  - Loads carry flip-flop c from in_carry.
  - Clears bit counter and sum shift register ss.
- ADD, each edge:
  - s = sa[0]^sb[0]^c.
  - c <= majority(sa[0], sb[0], c).
  - sa and sb shift right by 1.
  - ss shifts right with s inserted at the MSB.
  - Counter increments.
- ADD -> DONE: on the edge that processes bit BITS-1, i.e. the BITS-th ADD edge.
  - out_sum <= final ss (including that bit).
  - out_carry <= final carry.
- DONE -> IDLE: unconditionally after one cycle.
- out_busy = (state==ADD). out_ready = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- Latency: start accepted on edge k. out_ready is high in the cycle following edge k+BITS. Throughput is one addition per BITS+2 cycles.
- in_start in ADD or DONE is ignored, not queued. in_a, in_b and in_carry may change freely after acceptance without affecting the result.
- Back-to-back: in_start held high continuously yields one addition per BITS+2 cycles.
- out_sum and out_carry:
  - Change only on the ADD->DONE edge or on reset.
  - Stay stable through IDLE and the next ADD phase.
- Arithmetic is modulo 2^BITS. Wrap-around is reported via out_carry only.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined: adds port out_overflow (out, 1), the signed overflow flag.
  - Value is carry into the MSB XOR carry out of the MSB, captured on the ADD->DONE edge.
  - Held with out_sum; reset value 0.
- Undefined: port absent, no extra logic. All other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles -> out_busy=0, out_ready=0, out_sum=0, out_carry=0 throughout.
- BITS=16, a=234, b=123, cin=0, start pulse -> out_busy high 16 cycles; out_ready pulses once, 17 cycles after the start edge; out_sum=357, out_carry=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> out_sum=16'h0000, out_carry=1. Then a=0, b=0, cin=1 -> out_sum=1, out_carry=0.
- Start, then in_start re-asserted with a=5, b=5 during ADD; operands changed mid-ADD -> first result unchanged (357 case); only one out_ready pulse; second request not executed.
- Assert in_rst 8 cycles into an addition -> next cycle IDLE, outputs zero, no out_ready. A new start with a=1000, b=24 -> out_sum=1024.
- With SERIAL_ADDER_OVERFLOW_EN: a=16'h7FFF, b=1 -> out_sum=16'h8000, out_overflow=1, out_carry=0. a=16'hFFFF, b=1 -> out_overflow=0, out_carry=1.
